// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: divide FSM encoding, register x0 and
// the default divider timing used by hazard_ctrl.
package pipe_pkg;

    // Divide-busy FSM encoding
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_LAST = 2'd2
    } div_state_e;

    // Architectural zero register; never a hazard source
    localparam logic [4:0] REG_X0 = 5'd0;

    // Default EX occupancy of DIV/DIVU/REM/REMU and the countdown width
    localparam int unsigned DIV_CYCLES_DFLT = 33;
    localparam int unsigned CNT_W_DFLT      = 6;

endpackage

// File: rtl/hazard_ctrl_lu.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. Purely combinational; x0 never produces a hazard.
module hazard_ctrl_lu
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    output logic       load_use_o
);

    logic rs1_match;
    logic rs2_match;

    // Compare each used ID source against the load destination
    always_comb begin
        rs1_match  = id_use_rs1_i && (id_rs1_i == ex_rd_i);
        rs2_match  = id_use_rs2_i && (id_rs2_i == ex_rd_i);
        load_use_o = ex_memread_i && (ex_rd_i != REG_X0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core: load-use stalls,
// taken-branch flushes and the divide-busy FSM that freezes the front end
// while the iterative divider occupies EX.
// Optional build macro HAZARD_CTRL_PERF_EN adds saturating performance
// counters for stall cycles, flush cycles and divide entries.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DFLT,
    parameter int unsigned CNT_W      = CNT_W_DFLT
) (
    input  logic        sys_clk,
    input  logic        sys_start,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_branch_taken_i,
    input  logic        ex_isdiv_i,
    output logic        pc_stall_o,
    output logic        ifid_hazard_o,
    output logic        ifid_flush_o,
    output logic        idex_flush_o,
    output logic        exmem_hold_o,
`ifdef HAZARD_CTRL_PERF_EN
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] div_cnt_o,
`endif
    output logic        div_busy_o
);

    // Entry cycle is spent in IDLE, so DIV_RUN starts at DIV_CYCLES-2 and
    // leaves when the count reaches 1; DIV_LAST is the final EX cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    hazard_ctrl_lu u_lu (
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .ex_memread_i (ex_memread_i),
        .ex_rd_i      (ex_rd_i),
        .load_use_o   (load_use)
    );

    // State and countdown registers with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_start) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: enter on a divide in EX, count down, release via DIV_LAST
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (ex_isdiv_i) begin
                    if (DIV_CYCLES == 2) begin
                        state_d = DIV_LAST;
                        cnt_d   = '0;
                    end else begin
                        state_d = DIV_RUN;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            DIV_RUN: begin
                // Never decrement past zero
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                if (cnt_q <= CNT_ONE) begin
                    state_d = DIV_LAST;
                end
            end
            DIV_LAST: begin
                // A divide seen here is the one still finishing; ignore it
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: divide beats branch, branch beats load-use; all zero in reset
    always_comb begin
        pc_stall_o    = 1'b0;
        ifid_hazard_o = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_hold_o  = 1'b0;
        div_busy_o    = 1'b0;
        if (sys_start) begin
            unique case (state_q)
                IDLE: begin
                    if (ex_isdiv_i) begin
                        // ID_EX holds through the same stall, no bubble
                        pc_stall_o    = 1'b1;
                        ifid_hazard_o = 1'b1;
                        exmem_hold_o  = 1'b1;
                        div_busy_o    = 1'b1;
                    end else if (ex_branch_taken_i) begin
                        ifid_flush_o = 1'b1;
                        idex_flush_o = 1'b1;
                    end else if (load_use) begin
                        pc_stall_o    = 1'b1;
                        ifid_hazard_o = 1'b1;
                        idex_flush_o  = 1'b1;
                    end
                end
                DIV_RUN: begin
                    pc_stall_o    = 1'b1;
                    ifid_hazard_o = 1'b1;
                    exmem_hold_o  = 1'b1;
                    div_busy_o    = 1'b1;
                end
                DIV_LAST: begin
                    // Result advances to MEM; a redirect may now take effect
                    div_busy_o = 1'b1;
                    if (ex_branch_taken_i) begin
                        ifid_flush_o = 1'b1;
                        idex_flush_o = 1'b1;
                    end
                end
                default: begin
                    div_busy_o = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [31:0] div_cnt_q;
    logic        div_entry;

    always_comb begin
        div_entry = sys_start && (state_q == IDLE) && ex_isdiv_i;
    end

    // Saturating event counters, cleared by reset
    always_ff @(posedge sys_clk) begin
        if (!sys_start) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            div_cnt_q   <= '0;
        end else begin
            if (pc_stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ifid_flush_o && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
            if (div_entry && (div_cnt_q != '1)) begin
                div_cnt_q <= div_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        stall_cnt_o = stall_cnt_q;
        flush_cnt_o = flush_cnt_q;
        div_cnt_o   = div_cnt_q;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised self-checking bench for hazard_ctrl. Two instances share the
// inputs: the default 33-cycle divider and a 2-cycle divider.
module tb_hazard_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_start;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, ex_isdiv;

    logic pc_stall [2];
    logic ifid_hazard [2];
    logic ifid_flush [2];
    logic idex_flush [2];
    logic exmem_hold [2];
    logic div_busy [2];
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt [2];
    logic [31:0] flush_cnt [2];
    logic [31:0] div_cnt [2];
`endif

    always #5 sys_clk = ~sys_clk;

    hazard_ctrl #(.DIV_CYCLES(33), .CNT_W(6)) u_dut0 (
        .sys_clk           (sys_clk),
        .sys_start         (sys_start),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_use_rs1_i      (id_use_rs1),
        .id_use_rs2_i      (id_use_rs2),
        .ex_memread_i      (ex_memread),
        .ex_rd_i           (ex_rd),
        .ex_branch_taken_i (ex_branch_taken),
        .ex_isdiv_i        (ex_isdiv),
        .pc_stall_o        (pc_stall[0]),
        .ifid_hazard_o     (ifid_hazard[0]),
        .ifid_flush_o      (ifid_flush[0]),
        .idex_flush_o      (idex_flush[0]),
        .exmem_hold_o      (exmem_hold[0]),
`ifdef HAZARD_CTRL_PERF_EN
        .stall_cnt_o       (stall_cnt[0]),
        .flush_cnt_o       (flush_cnt[0]),
        .div_cnt_o         (div_cnt[0]),
`endif
        .div_busy_o        (div_busy[0])
    );

    hazard_ctrl #(.DIV_CYCLES(2), .CNT_W(2)) u_dut1 (
        .sys_clk           (sys_clk),
        .sys_start         (sys_start),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_use_rs1_i      (id_use_rs1),
        .id_use_rs2_i      (id_use_rs2),
        .ex_memread_i      (ex_memread),
        .ex_rd_i           (ex_rd),
        .ex_branch_taken_i (ex_branch_taken),
        .ex_isdiv_i        (ex_isdiv),
        .pc_stall_o        (pc_stall[1]),
        .ifid_hazard_o     (ifid_hazard[1]),
        .ifid_flush_o      (ifid_flush[1]),
        .idex_flush_o      (idex_flush[1]),
        .exmem_hold_o      (exmem_hold[1]),
`ifdef HAZARD_CTRL_PERF_EN
        .stall_cnt_o       (stall_cnt[1]),
        .flush_cnt_o       (flush_cnt[1]),
        .div_cnt_o         (div_cnt[1]),
`endif
        .div_busy_o        (div_busy[1])
    );

    // Branch and divide resolve in the same stage, so never together
    always @(posedge sys_clk) begin
        assert (!(ex_isdiv && ex_branch_taken))
            else $error("FAIL stimulus: ex_isdiv and ex_branch_taken both high");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: remaining EX cycles of the divide in flight (0 = none)
    int unsigned     div_len [2] = '{33, 2};
    int unsigned     left [2]    = '{0, 0};
    longint unsigned m_stall [2] = '{0, 0};
    longint unsigned m_flush [2] = '{0, 0};
    longint unsigned m_div [2]   = '{0, 0};

    function automatic longint unsigned sat_inc(input longint unsigned v, input bit en);
        if (en && v < 64'hFFFF_FFFF) return v + 1;
        return v;
    endfunction

    // Check one cycle of both DUTs, then advance the model across the edge
    task automatic cycle(input string tag);
        int unsigned     nx_left [2];
        longint unsigned nx_stall [2], nx_flush [2], nx_div [2];
        bit lu;
        #1;
        lu = ex_memread && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        for (int k = 0; k < 2; k++) begin
            bit e_stall, e_haz, e_iff, e_idf, e_hold, e_busy, entry;
            e_stall = 0; e_haz = 0; e_iff = 0; e_idf = 0; e_hold = 0; e_busy = 0;
            entry = 0;
            nx_left[k] = 0;
            if (sys_start) begin
                if (left[k] == 0) begin
                    if (ex_isdiv) begin
                        entry = 1;
                        e_stall = 1; e_haz = 1; e_hold = 1; e_busy = 1;
                        nx_left[k] = div_len[k] - 1;
                    end else if (ex_branch_taken) begin
                        e_iff = 1; e_idf = 1;
                    end else if (lu) begin
                        e_stall = 1; e_haz = 1; e_idf = 1;
                    end
                end else if (left[k] > 1) begin
                    e_stall = 1; e_haz = 1; e_hold = 1; e_busy = 1;
                    nx_left[k] = left[k] - 1;
                end else begin
                    e_busy = 1;
                    if (ex_branch_taken) begin
                        e_iff = 1; e_idf = 1;
                    end
                end
            end
            check($sformatf("%s[%0d] pc_stall", tag, k), pc_stall[k], e_stall);
            check($sformatf("%s[%0d] ifid_hazard", tag, k), ifid_hazard[k], e_haz);
            check($sformatf("%s[%0d] ifid_flush", tag, k), ifid_flush[k], e_iff);
            check($sformatf("%s[%0d] idex_flush", tag, k), idex_flush[k], e_idf);
            check($sformatf("%s[%0d] exmem_hold", tag, k), exmem_hold[k], e_hold);
            check($sformatf("%s[%0d] div_busy", tag, k), div_busy[k], e_busy);
`ifdef HAZARD_CTRL_PERF_EN
            check($sformatf("%s[%0d] stall_cnt", tag, k), stall_cnt[k], m_stall[k][31:0]);
            check($sformatf("%s[%0d] flush_cnt", tag, k), flush_cnt[k], m_flush[k][31:0]);
            check($sformatf("%s[%0d] div_cnt", tag, k), div_cnt[k], m_div[k][31:0]);
`endif
            if (sys_start) begin
                nx_stall[k] = sat_inc(m_stall[k], e_stall);
                nx_flush[k] = sat_inc(m_flush[k], e_iff);
                nx_div[k]   = sat_inc(m_div[k], entry);
            end else begin
                nx_stall[k] = 0; nx_flush[k] = 0; nx_div[k] = 0;
            end
        end
        @(posedge sys_clk);
        for (int k = 0; k < 2; k++) begin
            left[k]    = nx_left[k];
            m_stall[k] = nx_stall[k];
            m_flush[k] = nx_flush[k];
            m_div[k]   = nx_div[k];
        end
        @(negedge sys_clk);
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_memread = 0;
        ex_branch_taken = 0; ex_isdiv = 0;
    endtask

    task automatic do_reset(input int n);
        sys_start = 0;
        for (int i = 0; i < n; i++) cycle("reset");
        sys_start = 1;
    endtask

    int hold_len, busy_len;

    initial begin
        idle_inputs();
        sys_start = 0;
        @(negedge sys_clk);

        // Reset held with a divide pending: everything stays low
        ex_isdiv = 1;
        do_reset(3);

        // Released: divide entry, then count freeze and busy lengths;
        // a branch pulse mid-divide must have no effect
        hold_len = 0; busy_len = 0;
        for (int i = 0; i < 40; i++) begin
            ex_isdiv = (i == 0);
            ex_branch_taken = (i == 10);
            #1;
            if (exmem_hold[0]) hold_len++;
            if (div_busy[0]) busy_len++;
            cycle("div33");
        end
        check("div33 hold_len", hold_len, 32);
        check("div33 busy_len", busy_len, 33);
        idle_inputs();

        // Load-use on rs2 with rd=5, then the same with rd=0
        ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        cycle("lu_rd5");
        ex_rd = 0; id_rs2 = 0;
        cycle("lu_rd0");
        // Branch together with a load-use match: flush only
        ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1; ex_branch_taken = 1;
        cycle("br_lu");
        idle_inputs();
        cycle("quiet");

        // Back-to-back divides with ex_isdiv held high
        ex_isdiv = 1;
        for (int i = 0; i < 70; i++) cycle("div_b2b");
        // Mid-divide reset clears the freeze
        do_reset(1);
        ex_isdiv = 0;
        for (int i = 0; i < 3; i++) cycle("post_rst");

        // Counter scenario: one load-use, one branch, one divide
        idle_inputs();
        do_reset(2);
        ex_memread = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        cycle("perf_lu");
        idle_inputs();
        ex_branch_taken = 1;
        cycle("perf_br");
        ex_branch_taken = 0; ex_isdiv = 1;
        cycle("perf_div");
        ex_isdiv = 0;
        for (int i = 0; i < 40; i++) cycle("perf_idle");
`ifdef HAZARD_CTRL_PERF_EN
        check("perf stall_cnt", stall_cnt[0], 33);
        check("perf flush_cnt", flush_cnt[0], 1);
        check("perf div_cnt", div_cnt[0], 1);
`endif

        // Random traffic, biased toward register collisions
        for (int i = 0; i < 3000; i++) begin
            sys_start       = ($urandom_range(0, 199) != 0);
            ex_memread      = $urandom_range(0, 1);
            ex_rd           = 5'($urandom_range(0, 3));
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_use_rs1      = $urandom_range(0, 1);
            id_use_rs2      = $urandom_range(0, 1);
            ex_isdiv        = ($urandom_range(0, 39) == 0);
            ex_branch_taken = !ex_isdiv && ($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
